cache_miss_ctrl: RTL and testbench

// - Control FSM for the 8-way set-associative cache; direct consumer of the pLRU tree.
// - Resolves hit/miss for a CPU request and picks the victim way (pLRU, optionally invalid-first).
// - Sequences dirty writeback and line fill over the pmem handshake.
// - Drives the tree's load/last_access so every completed access updates replacement state.

---
 rtl/cache_miss_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss/hit control FSM for the 8-way set-associative cache: victim selection, writeback, fill.
// Optional INVALID_FIRST_EN: on a miss, prefer the lowest-numbered invalid way over the pLRU way.
module cache_miss_ctrl #(
    parameter int unsigned s_index = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [s_index-1:0] index,
    input  logic               hit,
    input  logic [2:0]         hit_way,
    input  logic [7:0]         valid_vec,
    input  logic [7:0]         dirty_vec,
    input  logic [2:0]         plru,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               plru_load,
    output logic [s_index-1:0] plru_index,
    output logic [2:0]         last_access,
    output logic [2:0]         way_sel,
    output logic               data_we,
    output logic               fill_we,
    output logic               valid_set,
    output logic               dirty_set,
    output logic               dirty_clr,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               pmem_addr_sel
);

    typedef enum logic [1:0] {StIdle, StCheck, StWb, StFill} state_e;

    state_e     state_q, state_d;
    logic [2:0] victim_q, victim_d;
    logic [2:0] victim_choice;
    logic       req;
    logic       is_write;

    assign req      = mem_read | mem_write;
    // Both asserted is illegal; the write wins.
    assign is_write = mem_write;

`ifdef INVALID_FIRST_EN
    always_comb begin
        victim_choice = plru;
        for (int i = 7; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                victim_choice = 3'(i);
            end
        end
    end
`else
    assign victim_choice = plru;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            victim_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        plru_load     = 1'b0;
        last_access   = 3'd0;
        way_sel       = 3'd0;
        data_we       = 1'b0;
        fill_we       = 1'b0;
        valid_set     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!req) begin
                    // Request abandoned during a miss sequence.
                    state_d = StIdle;
                end else if (hit) begin
                    mem_resp    = 1'b1;
                    plru_load   = 1'b1;
                    last_access = hit_way;
                    way_sel     = hit_way;
                    data_we     = is_write;
                    dirty_set   = is_write;
                    state_d     = StIdle;
                end else begin
                    victim_d = victim_choice;
                    if (valid_vec[victim_choice] && dirty_vec[victim_choice]) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWb: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    dirty_clr = 1'b1;
                    state_d   = StFill;
                end
            end
            StFill: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    fill_we   = 1'b1;
                    valid_set = 1'b1;
                    dirty_clr = 1'b1;
                    state_d   = StCheck;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Index only forwarded while the tree is being updated so idle outputs stay 0.
    assign plru_index = plru_load ? index : '0;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: env models pmem and tag hits, monitor checks events.
module tb_cache_miss_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write;
    logic [2:0] index;
    logic       hit;
    logic [2:0] hit_way;
    logic [7:0] valid_vec, dirty_vec;
    logic [2:0] plru;
    logic       pmem_resp;
    logic       mem_resp, plru_load, data_we, fill_we, valid_set, dirty_set, dirty_clr;
    logic       pmem_read, pmem_write, pmem_addr_sel;
    logic [2:0] plru_index, last_access, way_sel;

    cache_miss_ctrl #(.s_index(3)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .index(index),
        .hit(hit), .hit_way(hit_way), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .plru(plru), .pmem_resp(pmem_resp), .mem_resp(mem_resp), .plru_load(plru_load),
        .plru_index(plru_index), .last_access(last_access), .way_sel(way_sel),
        .data_we(data_we), .fill_we(fill_we), .valid_set(valid_set), .dirty_set(dirty_set),
        .dirty_clr(dirty_clr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       kind;  // 0 = writeback done, 1 = fill, 2 = CPU response
        logic [2:0] way;
        logic     wr;
    } ev_t;

    ev_t        evq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_victim = 3'd0;
    int         resp_delay = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_victim(input logic [7:0] vv, input logic [2:0] pl);
        logic [2:0] v;
        v = pl;
`ifdef INVALID_FIRST_EN
        if (vv != 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                if (!vv[i]) begin
                    v = 3'(i);
                    break;
                end
            end
        end
`endif
        return v;
    endfunction

    function automatic int all_outputs();
        return int'({mem_resp, plru_load, plru_index, last_access, way_sel, data_we, fill_we,
                     valid_set, dirty_set, dirty_clr, pmem_read, pmem_write, pmem_addr_sel});
    endfunction

    task automatic push_ev(input int kind, input logic [2:0] way, input logic wr);
        ev_t e;
        e.kind = kind;
        e.way  = way;
        e.wr   = wr;
        evq.push_back(e);
    endtask

    // Physical memory and tag-array environment.
    initial begin
        int cnt;
        cnt       = 0;
        pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                cnt       = 0;
                pmem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !pmem_resp) begin
                // Scramble replacement inputs; the latched victim must not follow them.
                plru      = 3'($urandom);
                valid_vec = 8'($urandom);
                if (cnt >= resp_delay) begin
                    pmem_resp = 1'b1;
                    cnt       = 0;
                    if (pmem_read) begin
                        hit     = 1'b1;
                        hit_way = exp_victim;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                pmem_resp = 1'b0;
            end
        end
    end

    // Monitor: per-cycle protocol rules plus scoreboard pops on each output event.
    initial begin
        logic       prev_act, prev_resp;
        logic [5:0] prev_sig;
        ev_t        e;
        prev_act = 1'b0;
        prev_resp = 1'b0;
        prev_sig = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_act = 1'b0;
            end else begin
                if (pmem_read || pmem_write)
                    chk("pmem_exclusive", int'(pmem_read && pmem_write), 0);
                if (pmem_write) chk("wb_addr_sel", pmem_addr_sel, 1);
                if (pmem_read) chk("fill_addr_sel", pmem_addr_sel, 0);
                if (prev_act && !prev_resp)
                    chk("pmem_stable", {pmem_read, pmem_write, way_sel, pmem_addr_sel},
                        prev_sig);
                if (plru_load || mem_resp) chk("load_eq_resp", plru_load, mem_resp);
                if (pmem_write && pmem_resp) begin
                    chk("wb_event_expected", int'(evq.size() > 0), 1);
                    if (evq.size() > 0) begin
                        e = evq.pop_front();
                        chk("wb_event_kind", e.kind, 0);
                        chk("wb_way", way_sel, e.way);
                        chk("wb_dirty_clr", dirty_clr, 1);
                    end
                end
                if (fill_we) begin
                    chk("fill_event_expected", int'(evq.size() > 0), 1);
                    if (evq.size() > 0) begin
                        e = evq.pop_front();
                        chk("fill_event_kind", e.kind, 1);
                        chk("fill_way", way_sel, e.way);
                        chk("fill_valid_set", valid_set, 1);
                        chk("fill_dirty_clr", dirty_clr, 1);
                        chk("fill_on_resp", int'(pmem_read && pmem_resp), 1);
                    end
                end
                if (mem_resp) begin
                    chk("resp_event_expected", int'(evq.size() > 0), 1);
                    if (evq.size() > 0) begin
                        e = evq.pop_front();
                        chk("resp_event_kind", e.kind, 2);
                        chk("resp_last_access", last_access, e.way);
                        chk("resp_way_sel", way_sel, e.way);
                        chk("resp_data_we", data_we, e.wr);
                        chk("resp_dirty_set", dirty_set, e.wr);
                        chk("resp_plru_index", plru_index, index);
                        chk("resp_no_pmem", int'(pmem_read || pmem_write), 0);
                    end
                end
                prev_act  = pmem_read || pmem_write;
                prev_resp = pmem_resp;
                prev_sig  = {pmem_read, pmem_write, way_sel, pmem_addr_sel};
            end
        end
    end

    task automatic setup(input logic [2:0] idx, input logic hit0, input logic [2:0] hway,
                         input logic [7:0] vv, input logic [7:0] dv, input logic [2:0] pl,
                         input int dly, output logic [2:0] v, output logic wbx);
        v   = model_victim(vv, pl);
        wbx = vv[v] & dv[v];
        index      = idx;
        hit        = hit0;
        hit_way    = hway;
        valid_vec  = vv;
        dirty_vec  = dv;
        plru       = pl;
        exp_victim = v;
        resp_delay = dly;
    endtask

    task automatic run_txn(input logic wr, input logic both, input logic [2:0] idx,
                           input logic hit0, input logic [2:0] hway, input logic [7:0] vv,
                           input logic [7:0] dv, input logic [2:0] pl, input int dly);
        logic [2:0] v;
        logic       wbx;
        logic       eff_wr;
        int         n;
        logic       got;
        @(posedge clk);
        #1;
        eff_wr = wr | both;
        setup(idx, hit0, hway, vv, dv, pl, dly, v, wbx);
        if (!hit0) begin
            if (wbx) push_ev(0, v, 1'b0);
            push_ev(1, v, 1'b0);
        end
        push_ev(2, hit0 ? hway : v, eff_wr);
        mem_write = eff_wr;
        mem_read  = ~wr | both;
        n   = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (mem_resp) got = 1'b1;
        end
        chk("resp_seen", got, 1);
        if (hit0) chk("hit_latency", n, 2);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v;
        logic       wbx;
        logic       seen;
        int         n;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        index = 3'd0;
        hit = 1'b0;
        hit_way = 3'd0;
        valid_vec = 8'h00;
        dirty_vec = 8'h00;
        plru = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        run_txn(1'b0, 1'b0, 3'd2, 1'b1, 3'd5, 8'hFF, 8'h00, 3'd0, 0);
        run_txn(1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 8'hFF, 8'h00, 3'd3, 2);
        run_txn(1'b1, 1'b0, 3'd4, 1'b0, 3'd0, 8'hFF, 8'h40, 3'd6, 1);
        run_txn(1'b0, 1'b0, 3'd3, 1'b0, 3'd0, 8'b11110111, 8'h00, 3'd1, 1);
        run_txn(1'b1, 1'b0, 3'd5, 1'b0, 3'd0, 8'hFF, 8'hFF, 3'd1, 0);
        run_txn(1'b1, 1'b1, 3'd6, 1'b1, 3'd0, 8'hFF, 8'h00, 3'd2, 0);
        run_txn(1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 8'h00, 8'hFF, 3'd7, 3);

        // Request dropped mid-writeback: WB and fill complete, no CPU response.
        @(posedge clk);
        #1;
        setup(3'd2, 1'b0, 3'd0, 8'hFF, 8'hFF, 3'd4, 3, v, wbx);
        push_ev(0, v, 1'b0);
        push_ev(1, v, 1'b0);
        mem_write = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (pmem_write) seen = 1'b1;
        end
        chk("drop_wb_started", seen, 1);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (fill_we) seen = 1'b1;
        end
        chk("drop_fill_done", seen, 1);
        repeat (3) @(negedge clk);
        chk("drop_idle_outputs", all_outputs(), 0);
        hit = 1'b0;

        // Reset during a fill: pmem_read must fall asynchronously with no fill write.
        @(posedge clk);
        #1;
        setup(3'd1, 1'b0, 3'd0, 8'hFF, 8'h00, 3'd2, 50, v, wbx);
        mem_read = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (pmem_read) seen = 1'b1;
        end
        chk("rst_fill_started", seen, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_drops_pmem_read", pmem_read, 0);
        chk("rst_no_fill_we", fill_we, 0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", all_outputs(), 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] vv;
            vv = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                    3'($urandom), 1'($urandom_range(0, 2) == 0), 3'($urandom), vv,
                    8'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", evq.size(), 0);
        chk("final_idle_outputs", all_outputs(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
